// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank scheduler: op encodings and FSM state.
package jk_pkg;

  // JK op encoding {J,K}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } jk_state_t;

endpackage

// File: rtl/jk_bank.sv
// Bank of N_BITS JK flip-flops with synchronous active-low reset.
module jk_bank #(
  parameter int unsigned N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_BITS-1:0] j,
  input  logic [N_BITS-1:0] k,
  output logic [N_BITS-1:0] q,
  output logic [N_BITS-1:0] q_n
);

  // Per-bit JK rule: q+ = J&~q | ~K&q
  always_ff @(posedge clk) begin
    if (!reset_n) q <= '0;
    else          q <= (j & ~q) | (~k & q);
  end

  assign q_n = ~q;

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler granting one JK command per cycle to a shared flop bank,
// with grant locking for atomic multi-command sequences.
module jk_bank_sched
  import jk_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned N_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [N_BITS*N_REQ-1:0]    req_mask,
  input  logic [N_REQ-1:0]           req_lock,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [N_BITS-1:0]          q,
  output logic [N_BITS-1:0]          q_n
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  jk_state_t         state, state_d;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]  owner, owner_d;
  logic [IDX_W-1:0]  pick, acc_id;
  logic              found, acc;
  int unsigned       idx;

  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [N_BITS-1:0] cmd_mask;
  logic [IDX_W-1:0]  cmd_id;
  logic [N_BITS-1:0] bank_j, bank_k;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N_REQ - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = 0;
    for (int unsigned o = 0; o < N_REQ; o++) begin
      idx = 32'(rr_ptr) + o;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // Next-state, pointer/owner update and ready generation
  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    owner_d   = owner;
    req_ready = '0;
    acc       = 1'b0;
    acc_id    = pick;
    case (state)
      ST_ARB: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          acc             = 1'b1;
          acc_id          = pick;
          if (req_lock[pick]) begin
            owner_d = pick;
            state_d = ST_LOCKED;
          end else begin
            rr_ptr_d = ptr_inc(pick);
          end
        end
      end
      ST_LOCKED: begin
        if (req_valid[owner]) begin
          req_ready[owner] = 1'b1;
          acc              = 1'b1;
          acc_id           = owner;
          if (!req_lock[owner]) begin
            rr_ptr_d = ptr_inc(owner);
            state_d  = ST_ARB;
          end
        end else if (!req_lock[owner]) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (!reset_n) begin
      req_ready = '0;
      acc       = 1'b0;
    end
  end

  // FSM state, round-robin pointer and lock owner
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_ARB;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_ptr_d;
      owner  <= owner_d;
    end
  end

  // Stage 1: command register captures the accepted command
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_op    <= JK_HOLD;
      cmd_mask  <= '0;
      cmd_id    <= '0;
    end else begin
      cmd_valid <= acc;
      cmd_op    <= req_op[32'(acc_id)*2 +: 2];
      cmd_mask  <= req_mask[32'(acc_id)*N_BITS +: N_BITS];
      cmd_id    <= acc_id;
    end
  end

  // Response pulse lines up with the q update of stage 2
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= cmd_valid;
      rsp_id    <= cmd_valid ? cmd_id : '0;
    end
  end

  assign bank_j = cmd_valid ? (cmd_mask & {N_BITS{cmd_op[1]}}) : '0;
  assign bank_k = cmd_valid ? (cmd_mask & {N_BITS{cmd_op[0]}}) : '0;

  jk_bank #(.N_BITS(N_BITS)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .j       (bank_j),
    .k       (bank_k),
    .q       (q),
    .q_n     (q_n)
  );

endmodule
